// File: rtl/load_store_request_queue_pkg.sv
// Shared types for the load/store request queue.
// Holds the LSU command enum, queue FSM states and queue entry layout.
package OpTypes;

  typedef enum logic [1:0] {
    CMD_LOAD,
    CMD_STORE,
    CMD_ATOMIC,
    CMD_FENCE
  } MemUnitCommand;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } lsq_state_t;

  localparam int LSQ_ADDR_W = 32;
  localparam int LSQ_DATA_W = 64;

  typedef struct packed {
    MemUnitCommand           command;
    logic [LSQ_ADDR_W-1:0]   addr;
    logic [LSQ_DATA_W-1:0]   storeData;
    logic                    invalidateTlb;
  } lsq_entry_t;

endpackage

// File: rtl/load_store_request_queue_fifo.sv
// Circular request storage for the load/store queue.
// Power-of-two depth so pointers wrap by natural overflow.
module request_fifo
  import OpTypes::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = lsq_entry_t
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [CW-1:0] CONE = 1;

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + PONE;
      end
      if (do_pop)
        rptr <= rptr + PONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/load_store_request_queue.sv
// In-order load/store request queue feeding a single-outstanding LSU.
// Issue register decouples LSU fields from the FIFO head.
module load_store_request_queue
  import OpTypes::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = LSQ_ADDR_W,
  parameter int DATA_WIDTH = LSQ_DATA_W
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  MemUnitCommand          reqCommand,
  input  logic [ADDR_WIDTH-1:0]  reqAddr,
  input  logic [DATA_WIDTH-1:0]  reqStoreData,
  input  logic                   reqInvalidateTlb,
  output logic                   lsuEnable,
  output MemUnitCommand          lsuCommand,
  output logic [ADDR_WIDTH-1:0]  lsuAddr,
  output logic [DATA_WIDTH-1:0]  lsuStoreData,
  output logic                   lsuInvalidateTlb,
  input  logic                   lsuDone,
  input  logic                   lsuLoadPagefault,
  input  logic                   lsuStorePagefault,
  input  logic [DATA_WIDTH-1:0]  lsuResult,
  output logic                   respValid,
  input  logic                   respReady,
  output logic [DATA_WIDTH-1:0]  respResult,
  output logic                   respLoadPagefault,
  output logic                   respStorePagefault,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  lsq_state_t state, state_nx;
  lsq_entry_t req_e, head_e, issue_q;

  logic full, empty, accept, push, pop;
  logic bypass, clear, done, fault;
  logic flushed_q, suppress;
  logic [DATA_WIDTH-1:0] res_q;
  logic lpf_q, spf_q;

  assign req_e = '{
    command:       reqCommand,
    addr:          LSQ_ADDR_W'(reqAddr),
    storeData:     LSQ_DATA_W'(reqStoreData),
    invalidateTlb: reqInvalidateTlb
  };

  assign reqReady = !full && !flush;
  assign accept   = reqValid && reqReady;
  assign done     = (state == ISSUE) && lsuDone;
  assign fault    = done && (lsuLoadPagefault || lsuStorePagefault);
  assign suppress = flushed_q || flush;
  // Empty queue in IDLE: load the issue register straight from the request.
  assign bypass   = (state == IDLE) && empty && accept;
  assign pop      = (state == IDLE) && !empty && !flush;
  assign push     = accept && !bypass && !fault;
  assign clear    = flush || fault;

  request_fifo #(
    .DEPTH (DEPTH),
    .T     (lsq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (req_e),
    .dout  (head_e),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop || bypass) state_nx = ISSUE;
      ISSUE:   if (lsuDone) state_nx = suppress ? IDLE : RESP;
      RESP:    if (flush || respReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      issue_q   <= '0;
      flushed_q <= 1'b0;
      res_q     <= '0;
      lpf_q     <= 1'b0;
      spf_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop)
        issue_q <= head_e;
      else if (bypass)
        issue_q <= req_e;
      // The LSU cannot be aborted; remember a flush until its done.
      if (state == ISSUE)
        flushed_q <= (flushed_q || flush) && !lsuDone;
      else
        flushed_q <= 1'b0;
      if (done) begin
        res_q <= lsuResult;
        lpf_q <= lsuLoadPagefault;
        spf_q <= lsuStorePagefault;
      end
    end
  end

  assign lsuEnable          = (state == ISSUE);
  assign lsuCommand         = issue_q.command;
  assign lsuAddr            = ADDR_WIDTH'(issue_q.addr);
  assign lsuStoreData       = DATA_WIDTH'(issue_q.storeData);
  assign lsuInvalidateTlb   = issue_q.invalidateTlb;
  assign respValid          = (state == RESP);
  assign respResult         = res_q;
  assign respLoadPagefault  = lpf_q;
  assign respStorePagefault = spf_q;

endmodule

// File: tb/tb_load_store_request_queue.sv
// Bench for the load/store request queue: directed scenarios,
// randomized traffic against a queue model, and a deep wrap test.
module tb_load_store_request_queue;
  import OpTypes::*;

  localparam int D  = 4;
  localparam int DB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN = 1'b0;
  logic          reqValid, reqReady;
  MemUnitCommand reqCommand;
  logic [31:0]   reqAddr;
  logic [63:0]   reqStoreData;
  logic          reqInvalidateTlb;
  logic          lsuEnable;
  MemUnitCommand lsuCommand;
  logic [31:0]   lsuAddr;
  logic [63:0]   lsuStoreData;
  logic          lsuInvalidateTlb;
  logic          lsuDone = 1'b0;
  logic          lsuLoadPagefault = 1'b0;
  logic          lsuStorePagefault = 1'b0;
  logic [63:0]   lsuResult = '0;
  logic          respValid, respReady;
  logic [63:0]   respResult;
  logic          respLoadPagefault, respStorePagefault;
  logic          flush;
  logic [2:0]    count;

  logic          b_rstN = 1'b0;
  logic          b_reqValid, b_reqReady;
  MemUnitCommand b_reqCommand;
  logic [31:0]   b_reqAddr;
  logic [63:0]   b_reqStoreData;
  logic          b_lsuEnable;
  MemUnitCommand b_lsuCommand;
  logic [31:0]   b_lsuAddr;
  logic [63:0]   b_lsuStoreData;
  logic          b_lsuInvalidateTlb;
  logic          b_lsuDone;
  logic [63:0]   b_lsuResult;
  logic          b_respValid;
  logic [63:0]   b_respResult;
  logic          b_respLpf, b_respSpf;
  logic [4:0]    b_count;

  load_store_request_queue #(.DEPTH(D)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqCommand(reqCommand), .reqAddr(reqAddr),
    .reqStoreData(reqStoreData),
    .reqInvalidateTlb(reqInvalidateTlb),
    .lsuEnable(lsuEnable), .lsuCommand(lsuCommand),
    .lsuAddr(lsuAddr), .lsuStoreData(lsuStoreData),
    .lsuInvalidateTlb(lsuInvalidateTlb),
    .lsuDone(lsuDone),
    .lsuLoadPagefault(lsuLoadPagefault),
    .lsuStorePagefault(lsuStorePagefault),
    .lsuResult(lsuResult),
    .respValid(respValid), .respReady(respReady),
    .respResult(respResult),
    .respLoadPagefault(respLoadPagefault),
    .respStorePagefault(respStorePagefault),
    .flush(flush), .count(count)
  );

  assign b_lsuDone   = b_lsuEnable;
  assign b_lsuResult = {32'h0, b_lsuAddr};

  load_store_request_queue #(.DEPTH(DB)) dut_b (
    .clk(clk), .rstN(b_rstN),
    .reqValid(b_reqValid), .reqReady(b_reqReady),
    .reqCommand(b_reqCommand), .reqAddr(b_reqAddr),
    .reqStoreData(b_reqStoreData),
    .reqInvalidateTlb(1'b0),
    .lsuEnable(b_lsuEnable), .lsuCommand(b_lsuCommand),
    .lsuAddr(b_lsuAddr), .lsuStoreData(b_lsuStoreData),
    .lsuInvalidateTlb(b_lsuInvalidateTlb),
    .lsuDone(b_lsuDone),
    .lsuLoadPagefault(1'b0), .lsuStorePagefault(1'b0),
    .lsuResult(b_lsuResult),
    .respValid(b_respValid), .respReady(1'b1),
    .respResult(b_respResult),
    .respLoadPagefault(b_respLpf),
    .respStorePagefault(b_respSpf),
    .flush(1'b0), .count(b_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] resf(input logic [31:0] a);
    return {~a, a};
  endfunction

  // LSU responder: done after a latency counted in enable cycles.
  int          lsu_lat = 2;
  int          cur_lat = 2;
  int          en_cnt  = 0;
  bit          lsu_rand = 1'b0;
  bit          lsu_stall = 1'b0;
  bit          lsu_fixed = 1'b0;
  logic [63:0] lsu_fixed_res = '0;
  logic [31:0] fault_addr = 32'h1;

  always @(posedge clk) begin
    #2;
    lsuDone = 1'b0;
    lsuLoadPagefault = 1'b0;
    lsuStorePagefault = 1'b0;
    if (!lsuEnable) en_cnt = 0;
    else begin
      en_cnt++;
      if (en_cnt == 1)
        cur_lat = lsu_rand ? int'($urandom_range(1, 4)) : lsu_lat;
      if (!lsu_stall && en_cnt >= cur_lat) begin
        lsuDone = 1'b1;
        lsuResult = lsu_fixed ? lsu_fixed_res : resf(lsuAddr);
        lsuLoadPagefault =
          (lsuAddr == fault_addr) && (lsuCommand == CMD_LOAD);
        lsuStorePagefault =
          (lsuAddr == fault_addr) && (lsuCommand == CMD_STORE);
      end
    end
  end

  // Transaction logs.
  logic [31:0] iss_log[$];
  logic [63:0] resp_log[$];
  logic [1:0]  pf_log[$];
  logic [63:0] b_log[$];
  bit          prev_en = 1'b0;
  int          bmax = 0;

  always @(negedge clk) begin
    if (lsuEnable && !prev_en) iss_log.push_back(lsuAddr);
    prev_en = lsuEnable;
    if (respValid && respReady) begin
      resp_log.push_back(respResult);
      pf_log.push_back({respLoadPagefault, respStorePagefault});
    end
    if (b_respValid) b_log.push_back(b_respResult);
    if (int'(b_count) > bmax) bmax = int'(b_count);
  end

  // Reference model for randomized traffic.
  bit          mon_on = 1'b0;
  lsq_entry_t  exp_q[$];
  logic [31:0] fly_q[$];
  lsq_entry_t  m_e;
  logic [31:0] m_a;
  int          acc = 0;
  int          iss = 0;
  bit          m_prev_en = 1'b0;
  bit          m_prev_hold = 1'b0;
  logic [31:0] m_prev_addr;
  logic [63:0] m_prev_res;

  always @(negedge clk) begin
    if (mon_on) begin
      if (lsuEnable && !m_prev_en) begin
        chk("issue_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          chk("issue_cmd", lsuCommand, m_e.command);
          chk("issue_addr", lsuAddr, m_e.addr);
          chk("issue_data", lsuStoreData, m_e.storeData);
          chk("issue_tlb", lsuInvalidateTlb, m_e.invalidateTlb);
          fly_q.push_back(m_e.addr);
          iss++;
        end
      end
      if (lsuEnable && m_prev_en)
        chk("lsu_stable", lsuAddr, m_prev_addr);
      chk("count", count, acc - iss);
      if (m_prev_hold) begin
        chk("resp_held", respValid, 1);
        chk("resp_stable", respResult, m_prev_res);
      end
      if (respValid && respReady) begin
        chk("resp_pending", fly_q.size() > 0, 1);
        if (fly_q.size() > 0) begin
          m_a = fly_q.pop_front();
          chk("resp_result", respResult, resf(m_a));
          chk("resp_pf", {respLoadPagefault, respStorePagefault}, 0);
        end
      end
      chk("req_ready", reqReady, (acc - iss) != D);
      if (reqValid && reqReady) begin
        exp_q.push_back('{reqCommand, reqAddr, reqStoreData,
                          reqInvalidateTlb});
        acc++;
      end
      m_prev_en   = lsuEnable;
      m_prev_addr = lsuAddr;
      m_prev_hold = respValid && !respReady;
      m_prev_res  = respResult;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input MemUnitCommand c, input logic [31:0] a,
                     input logic [63:0] d);
    reqValid = 1'b1;
    reqCommand = c;
    reqAddr = a;
    reqStoreData = d;
    reqInvalidateTlb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    respReady = 1'b1;
    reqValid = 1'b0;
    while ((lsuEnable || respValid || count != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", n < 300, 1);
  endtask

  function automatic void clear_logs();
    iss_log.delete();
    resp_log.delete();
    pf_log.delete();
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reqValid = 0; flush = 0; respReady = 0;
    reqCommand = CMD_LOAD; reqAddr = 0;
    reqStoreData = 0; reqInvalidateTlb = 0;
    b_reqValid = 0; b_reqCommand = CMD_STORE;
    b_reqAddr = 0; b_reqStoreData = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", lsuEnable, 0);
    chk("rst_resp", respValid, 0);
    chk("rst_count", count, 0);
    rstN = 1'b1;
    b_rstN = 1'b1;
    step();
    chk("rst_ready", reqReady, 1);
    chk("rst_addr", lsuAddr, 0);
    chk("rst_result", respResult, 0);
    chk("rst_b_count", b_count, 0);

    // Single load: enable at t+1, response at t+5, then held.
    lsu_lat = 4; lsu_fixed = 1; lsu_fixed_res = 64'hDEADBEEF;
    enq(CMD_LOAD, 32'h1000, 0);
    step();
    reqValid = 0;
    chk("t1_en", lsuEnable, 1);
    chk("t1_addr", lsuAddr, 32'h1000);
    chk("t1_cmd", lsuCommand, CMD_LOAD);
    chk("t1_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_busy_en", lsuEnable, 1);
      chk("t1_busy_resp", respValid, 0);
    end
    step();
    chk("t1_resp", respValid, 1);
    chk("t1_result", respResult, 64'hDEADBEEF);
    enq(CMD_LOAD, 32'h2000, 0);
    step();
    reqValid = 0;
    chk("hold_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", respValid, 1);
      chk("hold_result", respResult, 64'hDEADBEEF);
      chk("hold_noissue", lsuEnable, 0);
    end
    respReady = 1;
    step();
    chk("hold_done", respValid, 0);
    chk("hold_idle_en", lsuEnable, 0);
    chk("hold_idle_count", count, 1);
    step();
    chk("next_en", lsuEnable, 1);
    chk("next_addr", lsuAddr, 32'h2000);
    chk("next_count", count, 0);
    lsu_fixed = 0;
    drain();

    // Fill to DEPTH behind a held response.
    lsu_lat = 1;
    respReady = 0;
    enq(CMD_LOAD, 32'h3000, 0);
    step();
    reqValid = 0;
    n = 0;
    while (!respValid && n < 20) begin step(); n++; end
    chk("fill_setup", respValid, 1);
    lsu_stall = 1;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      enq(CMD_STORE, 32'h4000 + 32'(i * 8), 64'(i));
      chk("fill_ready", reqReady, 1);
      step();
      chk("fill_count", count, i + 1);
    end
    chk("full_ready", reqReady, 0);
    enq(CMD_STORE, 32'h4020, 4);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_hold_ready", reqReady, 0);
      chk("full_hold_count", count, 4);
    end
    respReady = 1;
    step();
    chk("full_idle_resp", respValid, 0);
    chk("full_idle_ready", reqReady, 0);
    chk("full_idle_count", count, 4);
    step();
    chk("full_pop_en", lsuEnable, 1);
    chk("full_pop_addr", lsuAddr, 32'h4000);
    chk("full_pop_count", count, 3);
    chk("full_pop_ready", reqReady, 1);
    step();
    reqValid = 0;
    chk("full_refill", count, 4);
    lsu_stall = 0;
    drain();
    chk("fill_issued", iss_log.size(), 5);
    for (int i = 0; i < iss_log.size(); i++)
      chk("fill_order", iss_log[i], 32'h4000 + 32'(i * 8));

    // Pagefault on the second of three loads.
    clear_logs();
    lsu_lat = 2;
    fault_addr = 32'h5008;
    respReady = 1;
    enq(CMD_LOAD, 32'h5000, 0); step();
    enq(CMD_LOAD, 32'h5008, 0); step();
    enq(CMD_LOAD, 32'h5010, 0); step();
    reqValid = 0;
    n = 0;
    while (!(lsuEnable && lsuAddr == 32'h5008) && n < 50) begin
      step(); n++;
    end
    chk("pf_issue2", lsuAddr, 32'h5008);
    chk("pf_count_before", count, 1);
    step();
    enq(CMD_LOAD, 32'h5018, 0);
    chk("pf_cycle_ready", reqReady, 1);
    step();
    reqValid = 0;
    chk("pf_count_after", count, 0);
    chk("pf_resp", respValid, 1);
    chk("pf_flag", respLoadPagefault, 1);
    drain();
    chk("pf_issued", iss_log.size(), 2);
    chk("pf_resps", resp_log.size(), 2);
    if (pf_log.size() == 2) begin
      chk("pf_first_flags", pf_log[0], 2'b00);
      chk("pf_second_flags", pf_log[1], 2'b10);
      chk("pf_first_result", resp_log[0], resf(32'h5000));
    end
    fault_addr = 32'h1;

    // Flush while the LSU is busy with two queued.
    clear_logs();
    lsu_lat = 6;
    enq(CMD_LOAD, 32'h6000, 0); step();
    enq(CMD_LOAD, 32'h6008, 0); step();
    enq(CMD_LOAD, 32'h6010, 0); step();
    chk("fl_count_before", count, 2);
    chk("fl_en_before", lsuEnable, 1);
    enq(CMD_LOAD, 32'h6018, 0);
    flush = 1;
    #1;
    chk("fl_ready", reqReady, 0);
    step();
    flush = 0;
    reqValid = 0;
    chk("fl_count", count, 0);
    chk("fl_en_held", lsuEnable, 1);
    n = 0;
    while (lsuEnable && n < 20) begin
      chk("fl_no_resp", respValid, 0);
      step(); n++;
    end
    chk("fl_en_dropped", lsuEnable, 0);
    chk("fl_suppressed", respValid, 0);
    step();
    chk("fl_idle_en", lsuEnable, 0);
    chk("fl_idle_resp", respValid, 0);
    chk("fl_issued", iss_log.size(), 1);
    chk("fl_resps", resp_log.size(), 0);

    // Asynchronous reset during ISSUE.
    clear_logs();
    lsu_stall = 1;
    enq(CMD_LOAD, 32'h7000, 0); step();
    enq(CMD_LOAD, 32'h7008, 0); step();
    reqValid = 0;
    chk("ar_en", lsuEnable, 1);
    chk("ar_count", count, 1);
    #2;
    rstN = 0;
    #1;
    chk("ar_en_low", lsuEnable, 0);
    chk("ar_resp_low", respValid, 0);
    chk("ar_count_low", count, 0);
    @(posedge clk);
    #1;
    rstN = 1;
    lsu_stall = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_quiet_en", lsuEnable, 0);
      chk("ar_quiet_resp", respValid, 0);
    end
    chk("ar_issued", iss_log.size(), 1);

    // Randomized traffic against the model.
    lsu_rand = 1;
    acc = 0; iss = 0;
    exp_q.delete(); fly_q.delete();
    mon_on = 1;
    for (int i = 0; i < 400; i++) begin
      reqValid = 1'($urandom_range(0, 1));
      reqCommand = MemUnitCommand'($urandom_range(0, 3));
      reqAddr = $urandom & 32'hffff_fff8;
      reqStoreData = {$urandom, $urandom};
      reqInvalidateTlb = 1'($urandom_range(0, 1));
      respReady = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    mon_on = 0;
    lsu_rand = 0;
    chk("rand_all_issued", iss, acc);
    chk("rand_all_resp", fly_q.size(), 0);

    // Deep queue: 40 entries through DEPTH=16 in order.
    b_log.delete();
    for (int i = 0; i < 40; i++) begin
      b_reqValid = 1;
      b_reqAddr = 32'h100 + 32'(i * 4);
      b_reqStoreData = 64'(i);
      n = 0;
      while (!b_reqReady && n < 100) begin step(); n++; end
      step();
    end
    b_reqValid = 0;
    n = 0;
    while (b_log.size() < 40 && n < 500) begin step(); n++; end
    chk("wrap_resps", b_log.size(), 40);
    for (int i = 0; i < b_log.size(); i++)
      chk("wrap_order", b_log[i], 64'h100 + 64'(i * 4));
    chk("wrap_full", bmax, DB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_request_queue.md
LOAD_STORE_REQUEST_QUEUE -- requirements
Module: load_store_request_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_WIDTH, default 32, request address width.
REQ-003 Parameter DATA_WIDTH, default 64, store-data/result width (covers int and FP sources).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstN  in  1  reset, asynchronous, active-low.
REQ-006 reqValid/reqReady  in/out  1/1  enqueue handshake; transfer when both high.
REQ-007 reqCommand  in  MemUnitCommand  load/store/atomic/fence command.
REQ-008 reqAddr  in  ADDR_WIDTH  effective address; reqStoreData  in  DATA_WIDTH; reqInvalidateTlb  in  1.
REQ-009 lsuEnable  out  1; lsuCommand, lsuAddr, lsuStoreData, lsuInvalidateTlb  out  issued entry fields.
REQ-010 lsuDone, lsuLoadPagefault, lsuStorePagefault  in  1 each; lsuResult  in  DATA_WIDTH.
REQ-011 respValid/respReady  out/in  1/1  completion handshake; respResult  out  DATA_WIDTH; respLoadPagefault, respStorePagefault  out  1.
REQ-012 flush  in  1  discard all unissued entries and any undelivered response.
REQ-013 count  out  $clog2(DEPTH)+1  number of queued, unissued entries.

Function
REQ-014 Entries SHALL issue strictly in enqueue order; one entry in flight at a time.
REQ-015 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when count>0; ISSUE->RESP on lsuDone; RESP->IDLE on respValid&&respReady.
REQ-016 In ISSUE, lsuEnable SHALL be 1 and lsu* fields SHALL be stable until and including the lsuDone cycle.
REQ-017 Entry SHALL be popped on the IDLE->ISSUE transition; lsu* fields come from an issue register, not the FIFO head.
REQ-018 Enqueue to empty queue while IDLE at cycle t SHALL yield lsuEnable=1 at t+1 (no combinational bypass).
REQ-019 On lsuDone, result and fault flags SHALL be captured; respValid=1 from next cycle, held with stable data until respReady.
REQ-020 reqReady SHALL be 0 exactly when count==DEPTH; simultaneous pop at full SHALL NOT admit a same-cycle enqueue.
REQ-021 Simultaneous enqueue and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 On a captured pagefault, all queued entries SHALL be discarded (count=0) in the capture cycle; enqueues that cycle SHALL be dropped.
REQ-023 flush in IDLE or RESP: queue emptied, respValid cleared, next state IDLE.
REQ-024 flush in ISSUE: lsuEnable held until lsuDone (LSU not abortable), that response suppressed, then IDLE.
REQ-025 flush SHALL take priority over a same-cycle enqueue; reqReady SHALL be 0 while flush=1.

Reset
REQ-026 On rstN low: state IDLE, pointers and count 0, lsuEnable 0, respValid 0, reqReady 1 after release, data registers 0.
REQ-027 Reset asserted mid-ISSUE SHALL drop the in-flight request with no response produced.

Structure
REQ-028 FSM state enum and queue-entry struct (command, addr, storeData, invalidateTlb) SHALL live in OpTypes; MemUnitCommand reused unchanged.
REQ-029 Storage SHALL be one sub-module, request_fifo (parametrised DEPTH, entry type), with push/pop/full/empty/count.

Verification
REQ-030 Single load addr 0x1000, LSU done after 3 cycles with result 0xDEADBEEF -> lsuEnable at t+1, respValid with 0xDEADBEEF at t+5.
REQ-031 Enqueue 5 stores, DEPTH=4, LSU stalled -> reqReady=0 after 4th, count=4; 5th accepted only after first pop.
REQ-032 Three loads, second gets lsuLoadPagefault -> second response has respLoadPagefault=1, third never issued, count=0.
REQ-033 flush during ISSUE with 2 queued -> lsuEnable held to lsuDone, no respValid, count=0, IDLE next.
REQ-034 respReady held 0 for 4 cycles -> respResult stable, no further issue; DEPTH=16 wrap test of 40 entries preserves order.
REQ-035 rstN pulsed low mid-ISSUE -> lsuEnable and respValid 0 asynchronously, count=0.
